// File: rtl/fir_out_buffer.sv
// Output buffer for the FIR stream: fixed-ratio decimation, FWFT FIFO, sticky overflow.
// Optional macro FIR_OUT_BUF_OVF_CNT_EN adds a saturating dropped-sample counter port.
module fir_out_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DECIM      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_sample,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_sample,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow
`ifdef FIR_OUT_BUF_OVF_CNT_EN
    ,
    output logic [15:0]                    ovf_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  overflow_q, overflow_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [15:0]           ovf_cnt_q, ovf_cnt_d;

    logic kept_c, full_c, pop_c, push_c, drop_c, we_c;

    // Handshake qualifiers; full/empty come from level, never from pointer compare
    assign kept_c = in_valid && (phase_q == '0);
    assign full_c = (level_q == LVL_W'(DEPTH));
    assign pop_c  = (level_q != '0) && out_ready;
    assign push_c = kept_c && (!full_c || pop_c);
    assign drop_c = kept_c && full_c && !pop_c;

    always_comb begin
        phase_d     = phase_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        ovf_cnt_d   = ovf_cnt_q;
        we_c        = 1'b0;
        out_valid_d = 1'b0;
        head_d      = '0;

        if (flush) begin
            phase_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            ovf_cnt_d  = '0;
        end else begin
            if (in_valid) begin
                phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
            end
            we_c = push_c;
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                level_d = level_q + LVL_W'(1);
            end else if (!push_c && pop_c) begin
                level_d = level_q - LVL_W'(1);
            end
            if (drop_c) begin
                overflow_d = 1'b1;
                if (ovf_cnt_q != 16'hFFFF) begin
                    ovf_cnt_d = ovf_cnt_q + 16'd1;
                end
            end
        end

        // Registered head: the entry being written this cycle becomes head if the queue was empty
        out_valid_d = (level_d != '0);
        if (out_valid_d) begin
            head_d = (we_c && (wr_ptr_q == rd_ptr_d)) ? in_sample : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            phase_q     <= '0;
            overflow_q  <= 1'b0;
            ovf_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            phase_q     <= phase_d;
            overflow_q  <= overflow_d;
            ovf_cnt_q   <= ovf_cnt_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = head_q;
    assign level      = level_q;
    assign overflow   = overflow_q;

`ifdef FIR_OUT_BUF_OVF_CNT_EN
    assign ovf_count = ovf_cnt_q;
`else
    logic unused_cnt_c;
    assign unused_cnt_c = ^ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer: three configurations driven by directed vectors.
module tb_fir_out_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance a: DECIM=4 DEPTH=16; b: DECIM=1 DEPTH=4; c: DECIM=1 DEPTH=8
    logic        in_valid_a, flush_a, out_ready_a, out_valid_a, overflow_a;
    logic [15:0] in_sample_a, out_sample_a;
    logic [4:0]  level_a;
    logic        in_valid_b, flush_b, out_ready_b, out_valid_b, overflow_b;
    logic [15:0] in_sample_b, out_sample_b;
    logic [2:0]  level_b;
    logic        in_valid_c, flush_c, out_ready_c, out_valid_c, overflow_c;
    logic [15:0] in_sample_c, out_sample_c;
    logic [3:0]  level_c;
`ifdef FIR_OUT_BUF_OVF_CNT_EN
    logic [15:0] ovf_a, ovf_b, ovf_c;
`endif

    fir_out_buffer #(.DATA_WIDTH(16), .DEPTH(16), .DECIM(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_sample(in_sample_a),
        .flush(flush_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_sample(out_sample_a), .level(level_a), .overflow(overflow_a)
`ifdef FIR_OUT_BUF_OVF_CNT_EN
        , .ovf_count(ovf_a)
`endif
    );

    fir_out_buffer #(.DATA_WIDTH(16), .DEPTH(4), .DECIM(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_sample(in_sample_b),
        .flush(flush_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sample(out_sample_b), .level(level_b), .overflow(overflow_b)
`ifdef FIR_OUT_BUF_OVF_CNT_EN
        , .ovf_count(ovf_b)
`endif
    );

    fir_out_buffer #(.DATA_WIDTH(16), .DEPTH(8), .DECIM(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_sample(in_sample_c),
        .flush(flush_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_sample(out_sample_c), .level(level_c), .overflow(overflow_c)
`ifdef FIR_OUT_BUF_OVF_CNT_EN
        , .ovf_count(ovf_c)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] q_c[$];
    int          max_level_a = 0;
    logic        prev_stall_c = 1'b0;
    logic [15:0] prev_sample_c = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic spurious(input string nm, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got output %0h, expected no output", nm, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop an expected sample whenever a real pop is presented
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid_a && out_ready_a && !flush_a) begin
                if (q_a.size() == 0) spurious("a_pop", 32'(out_sample_a));
                else check("a_pop", 32'(out_sample_a), 32'(q_a.pop_front()));
            end
            if (int'(level_a) > max_level_a) max_level_a = int'(level_a);
        end
    end

    always @(negedge clk) begin
        if (rst && out_valid_b && out_ready_b && !flush_b) begin
            if (q_b.size() == 0) spurious("b_pop", 32'(out_sample_b));
            else check("b_pop", 32'(out_sample_b), 32'(q_b.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall_c && out_valid_c)
                check("c_hold", 32'(out_sample_c), 32'(prev_sample_c));
            if (out_valid_c && out_ready_c && !flush_c) begin
                if (q_c.size() == 0) spurious("c_pop", 32'(out_sample_c));
                else check("c_pop", 32'(out_sample_c), 32'(q_c.pop_front()));
            end
            prev_stall_c  = out_valid_c && !out_ready_c;
            prev_sample_c = out_sample_c;
        end
    end

    task automatic drain_b();
        out_ready_b = 1'b1;
        for (int k = 0; k < 40 && out_valid_b; k++) step();
        check("b_drained", 32'(out_valid_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        {in_valid_a, flush_a, out_ready_a, in_sample_a} = '0;
        {in_valid_b, flush_b, out_ready_b, in_sample_b} = '0;
        {in_valid_c, flush_c, out_ready_c, in_sample_c} = '0;
        repeat (2) @(negedge clk);
        check("rst_valid_a",  32'(out_valid_a),  32'd0);
        check("rst_sample_a", 32'(out_sample_a), 32'd0);
        check("rst_level_a",  32'(level_a),      32'd0);
        check("rst_ovf_a",    32'(overflow_a),   32'd0);
        check("rst_valid_b",  32'(out_valid_b),  32'd0);
        check("rst_valid_c",  32'(out_valid_c),  32'd0);
        step();
        rst = 1'b1;
        step();

        // Decimation by 4: only 1 and 5 survive
        out_ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid_a  = 1'b1;
            in_sample_a = 16'(i);
            if (i == 1 || i == 5) q_a.push_back(16'(i));
            step();
        end
        in_valid_a = 1'b0;
        repeat (3) step();
        check("a_max_level", 32'(max_level_a), 32'd1);
        check("a_ovf",       32'(overflow_a),  32'd0);

        // Flush resets the decimation phase: 30 kept, 31 flushed, 32 kept
        in_valid_a = 1'b1; in_sample_a = 16'd30; q_a.push_back(16'd30);
        step();
        in_valid_a = 1'b0;
        repeat (2) step();
        in_valid_a = 1'b1; in_sample_a = 16'd31; flush_a = 1'b1;
        step();
        flush_a = 1'b0; in_sample_a = 16'd32; q_a.push_back(16'd32);
        step();
        in_valid_a = 1'b0;
        repeat (3) step();

        // Overflow with DEPTH=4: 10..13 stored, 14 and 15 dropped
        out_ready_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid_b  = 1'b1;
            in_sample_b = 16'(10 + i);
            if (i < 4) q_b.push_back(16'(10 + i));
            step();
            if (i == 3) begin
                check("b_full_level", 32'(level_b),    32'd4);
                check("b_full_ovf",   32'(overflow_b), 32'd0);
            end
            if (i == 4) check("b_ovf_set", 32'(overflow_b), 32'd1);
        end
        in_valid_b = 1'b0;
        check("b_level4", 32'(level_b), 32'd4);
`ifdef FIR_OUT_BUF_OVF_CNT_EN
        check("b_ovf_count", 32'(ovf_b), 32'd2);
`endif
        drain_b();
        check("b_empty_sample", 32'(out_sample_b), 32'd0);
        check("b_empty_level",  32'(level_b),      32'd0);
        check("b_ovf_sticky",   32'(overflow_b),   32'd1);
        out_ready_b = 1'b0;
        flush_b = 1'b1;
        step();
        flush_b = 1'b0;
        check("b_flush_ovf", 32'(overflow_b), 32'd0);

        // Full with simultaneous pop: 5 accepted while 1 leaves
        for (int i = 1; i <= 4; i++) begin
            in_valid_b = 1'b1; in_sample_b = 16'(i); q_b.push_back(16'(i));
            step();
        end
        in_sample_b = 16'd5; q_b.push_back(16'd5); out_ready_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        check("b_pp_level", 32'(level_b),    32'd4);
        check("b_pp_ovf",   32'(overflow_b), 32'd0);
        drain_b();

        // Flush priority over push and pop
        out_ready_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_b = 1'b1; in_sample_b = 16'(20 + i);
            step();
        end
        check("b_hold3", 32'(level_b), 32'd3);
        flush_b = 1'b1; in_valid_b = 1'b1; in_sample_b = 16'd99; out_ready_b = 1'b1;
        step();
        flush_b = 1'b0; in_valid_b = 1'b0;
        check("b_fl_level", 32'(level_b),     32'd0);
        check("b_fl_valid", 32'(out_valid_b), 32'd0);
        check("b_fl_ovf",   32'(overflow_b),  32'd0);
        in_valid_b = 1'b1; in_sample_b = 16'd7; q_b.push_back(16'd7);
        step();
        in_valid_b = 1'b0;
        drain_b();

        // Async reset mid-stream with level=3 and overflow set
        out_ready_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid_b = 1'b1; in_sample_b = 16'(40 + i);
            if (i == 0) q_b.push_back(16'd40);
            step();
        end
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;
        check("b_pre_level", 32'(level_b),    32'd3);
        check("b_pre_ovf",   32'(overflow_b), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",  32'(out_valid_b),  32'd0);
        check("ar_level",  32'(level_b),      32'd0);
        check("ar_ovf",    32'(overflow_b),   32'd0);
        check("ar_sample", 32'(out_sample_b), 32'd0);
`ifdef FIR_OUT_BUF_OVF_CNT_EN
        check("ar_ovf_count", 32'(ovf_b), 32'd0);
`endif
        q_b.delete();
        repeat (2) step();
        rst = 1'b1;
        step();
        in_valid_b = 1'b1; in_sample_b = 16'd50; q_b.push_back(16'd50); out_ready_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        drain_b();

        // Backpressure: ready toggles every cycle while 20 samples stream in
        begin
            int sent = 0;
            for (int t = 0; t < 100 && (sent < 20 || out_valid_c); t++) begin
                out_ready_c = t[0];
                in_valid_c  = (sent < 20) && (t % 3 != 2);
                if (in_valid_c) begin
                    in_sample_c = 16'(100 + sent);
                    q_c.push_back(16'(100 + sent));
                    sent++;
                end
                step();
            end
        end
        in_valid_c = 1'b0;
        check("c_drained", 32'(out_valid_c), 32'd0);
        check("c_ovf",     32'(overflow_c),  32'd0);

        check("a_q_left", 32'(q_a.size()), 32'd0);
        check("b_q_left", 32'(q_b.size()), 32'd0);
        check("c_q_left", 32'(q_c.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
